// File: rtl/ahb_sram_if_mb_if.sv
// AHB-Lite slave bus and SRAM bank-array signals of ahb_sram_if_mb.
// The slave modport is the interface block; the master modport is the fabric/array side.
interface ahb_sram_if_mb_if #(
    parameter int NUM_BANKS = 2,
    parameter int BANK_AW   = 13
);
    logic                   hsel;
    logic                   hwrite;
    logic                   hready;
    logic [2:0]             hsize;
    logic [1:0]             htrans;
    logic [2:0]             hburst;
    logic [31:0]            haddr;
    logic [31:0]            hwdata;
    logic [NUM_BANKS*32-1:0] sram_rdata;

    logic                   hready_resp;
    logic [1:0]             hresp;
    logic [31:0]            hrdata;
    logic                   sram_w_en;
    logic [BANK_AW-1:0]     sram_addr_out;
    logic [31:0]            sram_wdata;
    logic [NUM_BANKS*4-1:0] bank_csn;

    modport slave (
        input  hsel, hwrite, hready, hsize, htrans, hburst,
        input  haddr, hwdata, sram_rdata,
        output hready_resp, hresp, hrdata, sram_w_en,
        output sram_addr_out, sram_wdata, bank_csn
    );

    modport master (
        output hsel, hwrite, hready, hsize, htrans, hburst,
        output haddr, hwdata, sram_rdata,
        input  hready_resp, hresp, hrdata, sram_w_en,
        input  sram_addr_out, sram_wdata, bank_csn
    );
endinterface

// File: rtl/ahb_sram_if_mb.sv
// AHB-Lite slave front end for a multi-bank synchronous SRAM array:
// byte-lane chip selects, read wait states and a two-cycle ERROR response.
module ahb_sram_if_mb #(
    parameter int NUM_BANKS = 2,
    parameter int BANK_AW   = 13,
    parameter int RD_WAIT   = 0
) (
    input logic             hclk,
    input logic             hreset,
    ahb_sram_if_mb_if.slave bus
);
    localparam int          BSEL_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [32:0] RANGE     = 33'(NUM_BANKS) << (BANK_AW + 2);
    localparam logic [1:0]  WAIT_LAST = 2'(RD_WAIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t             state_q, state_d;
    logic [BANK_AW-1:0] addr_q, addr_d;
    logic [BSEL_W-1:0]  bank_q, bank_d;
    logic [3:0]         lanes_q, lanes_d;
    logic [1:0]         cnt_q, cnt_d;

    logic               illegal;
    logic               accept;
    logic [3:0]         lanes_in;
    logic [BSEL_W-1:0]  bank_in;

    logic               rdy;
    logic [1:0]         resp;
    logic               wen;
    logic               csn_en;
    logic               rd_final;
    logic [31:0]        rdata;
    logic [NUM_BANKS*4-1:0] csn;

    logic               unused_hburst;
    assign unused_hburst = ^bus.hburst;

    // Address-phase decode: lane pattern plus legality of size/alignment/range.
    always_comb begin
        lanes_in = 4'b1111;
        illegal  = 1'b0;
        unique case (bus.hsize)
            3'd0:    lanes_in = ~(4'b0001 << bus.haddr[1:0]);
            3'd1:    lanes_in = bus.haddr[1] ? 4'b0011 : 4'b1100;
            3'd2:    lanes_in = 4'b0000;
            default: illegal  = 1'b1;
        endcase
        if (bus.hsize == 3'd1 && bus.haddr[0])
            illegal = 1'b1;
        if (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00)
            illegal = 1'b1;
        if ({1'b0, bus.haddr} >= RANGE)
            illegal = 1'b1;
    end

    if (NUM_BANKS > 1) begin : g_bank
        assign bank_in = bus.haddr[BANK_AW+2 +: BSEL_W];
    end else begin : g_one_bank
        assign bank_in = '0;
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            bank_q  <= '0;
            lanes_q <= 4'b1111;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bank_q  <= bank_d;
            lanes_q <= lanes_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        bank_d   = bank_q;
        lanes_d  = lanes_q;
        cnt_d    = cnt_q;
        rdy      = 1'b1;
        resp     = 2'b00;
        wen      = 1'b1;
        csn_en   = 1'b0;
        rd_final = 1'b0;

        unique case (state_q)
            ST_IDLE: ;
            ST_WR: begin
                wen    = 1'b0;
                csn_en = 1'b1;
            end
            ST_RD: begin
                rdy     = 1'b0;
                csn_en  = 1'b1;
                cnt_d   = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (cnt_q != WAIT_LAST) begin
                    rdy   = 1'b0;
                    cnt_d = cnt_q + 2'd1;
                end else begin
                    rd_final = 1'b1;
                end
            end
            ST_ERR1: begin
                rdy     = 1'b0;
                resp    = 2'b01;
                state_d = ST_ERR2;
            end
            ST_ERR2: resp = 2'b01;
            default: state_d = ST_IDLE;
        endcase

        // A new address phase is only sampled on cycles that complete the data phase.
        accept = rdy & bus.hsel & bus.hready & bus.htrans[1];
        if (rdy) begin
            cnt_d = '0;
            if (!accept) begin
                state_d = ST_IDLE;
            end else begin
                addr_d  = bus.haddr[BANK_AW+1:2];
                bank_d  = bank_in;
                lanes_d = lanes_in;
                if (illegal)
                    state_d = ST_ERR1;
                else if (bus.hwrite)
                    state_d = ST_WR;
                else
                    state_d = ST_RD;
            end
        end
    end

    always_comb begin
        rdata = '0;
        csn   = '1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_q == BSEL_W'(b)) begin
                if (rd_final)
                    rdata = bus.sram_rdata[32*b +: 32];
                if (csn_en)
                    csn[4*b +: 4] = lanes_q;
            end
        end
    end

    assign bus.hready_resp   = rdy;
    assign bus.hresp         = resp;
    assign bus.hrdata        = rdata;
    assign bus.sram_w_en     = wen;
    assign bus.sram_addr_out = addr_q;
    assign bus.sram_wdata    = bus.hwdata;
    assign bus.bank_csn      = csn;
endmodule

// File: tb/tb_ahb_sram_if_mb.sv
// Bench for ahb_sram_if_mb: one instance with RD_WAIT=0, one with RD_WAIT=3,
// each against a byte-lane SRAM array and a transaction-level expectation queue.
module tb_ahb_sram_if_mb;
  localparam logic [31:0] RANGE = 32'h0001_0000;

  typedef struct {
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        wen;
    logic [7:0]  csn;
    logic [12:0] addr;
    bit          chk_addr;
    logic [31:0] wdata;
    bit          chk_wdata;
    bit          fin_rd;
    bit          is_wr;
  } exp_t;

  typedef struct {
    bit          acc;
    bit          err;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic hclk;
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic        rst_s    [2];
  logic        hsel_s   [2];
  logic        hwrite_s [2];
  logic        hready_s [2];
  logic [2:0]  hsize_s  [2];
  logic [1:0]  htrans_s [2];
  logic [2:0]  hburst_s [2];
  logic [31:0] haddr_s  [2];
  logic [31:0] hwdata_s [2];
  logic [63:0] sram_q   [2];

  logic        rdy_o   [2];
  logic [1:0]  resp_o  [2];
  logic [31:0] rdata_o [2];
  logic        wen_o   [2];
  logic [12:0] addr_o  [2];
  logic [31:0] wdata_o [2];
  logic [7:0]  csn_o   [2];

  ahb_sram_if_mb_if #(.NUM_BANKS(2), .BANK_AW(13)) bus0 ();
  ahb_sram_if_mb_if #(.NUM_BANKS(2), .BANK_AW(13)) bus1 ();

  ahb_sram_if_mb #(.NUM_BANKS(2), .BANK_AW(13), .RD_WAIT(0)) dut0 (
    .hclk(hclk), .hreset(rst_s[0]), .bus(bus0));
  ahb_sram_if_mb #(.NUM_BANKS(2), .BANK_AW(13), .RD_WAIT(3)) dut1 (
    .hclk(hclk), .hreset(rst_s[1]), .bus(bus1));

  assign bus0.hsel = hsel_s[0];
  assign bus0.hwrite = hwrite_s[0];
  assign bus0.hready = hready_s[0];
  assign bus0.hsize = hsize_s[0];
  assign bus0.htrans = htrans_s[0];
  assign bus0.hburst = hburst_s[0];
  assign bus0.haddr = haddr_s[0];
  assign bus0.hwdata = hwdata_s[0];
  assign bus0.sram_rdata = sram_q[0];
  assign rdy_o[0] = bus0.hready_resp;
  assign resp_o[0] = bus0.hresp;
  assign rdata_o[0] = bus0.hrdata;
  assign wen_o[0] = bus0.sram_w_en;
  assign addr_o[0] = bus0.sram_addr_out;
  assign wdata_o[0] = bus0.sram_wdata;
  assign csn_o[0] = bus0.bank_csn;

  assign bus1.hsel = hsel_s[1];
  assign bus1.hwrite = hwrite_s[1];
  assign bus1.hready = hready_s[1];
  assign bus1.hsize = hsize_s[1];
  assign bus1.htrans = htrans_s[1];
  assign bus1.hburst = hburst_s[1];
  assign bus1.haddr = haddr_s[1];
  assign bus1.hwdata = hwdata_s[1];
  assign bus1.sram_rdata = sram_q[1];
  assign rdy_o[1] = bus1.hready_resp;
  assign resp_o[1] = bus1.hresp;
  assign rdata_o[1] = bus1.hrdata;
  assign wen_o[1] = bus1.sram_w_en;
  assign addr_o[1] = bus1.sram_addr_out;
  assign wdata_o[1] = bus1.sram_wdata;
  assign csn_o[1] = bus1.bank_csn;

  // Byte-wide synchronous SRAMs: 2 banks x 4 lanes per instance.
  logic [7:0] mem [2][2][4][8192];
  always @(posedge hclk) begin
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 2; b++)
        for (int l = 0; l < 4; l++)
          if (csn_o[d][4*b+l] == 1'b0) begin
            if (wen_o[d] == 1'b0)
              mem[d][b][l][addr_o[d]] <= wdata_o[d][8*l +: 8];
            else
              sram_q[d][32*b+8*l +: 8] <= mem[d][b][l][addr_o[d]];
          end
  end

  logic [31:0] ref_mem [int];
  xfer_t       prev [2];
  exp_t        q0 [$];
  exp_t        q1 [$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_rd [2];
  logic [7:0]  last_wcsn [2];
  logic [12:0] last_waddr [2];
  int          low_run [2];
  int          last_low [2];
  int          err_cyc [2];

  task automatic chk(input int d, input string nm,
                     input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %h, expected %h at %0t",
               d, nm, act, expv, $time);
    end
  endtask

  function automatic int rwait(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [3:0] lane_sel(logic [2:0] size, logic [1:0] a);
    if (size == 3'd2) return 4'b0000;
    if (size == 3'd1) return a[1] ? 4'b0011 : 4'b1100;
    case (a)
      2'd0: return 4'b1110;
      2'd1: return 4'b1101;
      2'd2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic bit is_illegal(logic [2:0] size, logic [31:0] a);
    if (size > 3'd2) return 1'b1;
    if (size == 3'd1 && a[0]) return 1'b1;
    if (size == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return a >= RANGE;
  endfunction

  function automatic xfer_t mk(logic sel, logic rdy, logic [1:0] trans, logic wr,
                               logic [2:0] size, logic [31:0] a, logic [31:0] data);
    xfer_t x;
    x.acc = sel && rdy && trans[1];
    x.err = x.acc && is_illegal(size, a);
    x.wr = wr;
    x.size = size;
    x.addr = a;
    x.data = data;
    return x;
  endfunction

  function automatic int dlen(int d, xfer_t x);
    if (!x.acc) return 1;
    if (x.err) return 2;
    if (x.wr) return 1;
    return 2 + rwait(d);
  endfunction

  // Expected outputs for cycle k of the data phase of transfer x.
  function automatic exp_t rec(int d, xfer_t x, int k);
    exp_t e;
    int bank;
    int key;
    logic [3:0] ln;
    logic [31:0] cur;
    e.rdy = 1'b1; e.resp = 2'b00; e.rdata = 32'h0; e.wen = 1'b1;
    e.csn = 8'hFF; e.addr = x.addr[14:2]; e.chk_addr = 0;
    e.wdata = x.data; e.chk_wdata = 0; e.fin_rd = 0; e.is_wr = 0;
    if (!x.acc) return e;
    if (x.err) begin
      e.resp = 2'b01;
      e.rdy = (k == 1);
      return e;
    end
    bank = int'(x.addr[15]);
    key = d * 65536 + int'(x.addr[15:2]);
    ln = lane_sel(x.size, x.addr[1:0]);
    if (x.wr) begin
      e.wen = 1'b0;
      e.csn[4*bank +: 4] = ln;
      e.chk_addr = 1;
      e.chk_wdata = 1;
      e.is_wr = 1;
      cur = ref_mem.exists(key) ? ref_mem[key] : 32'hx;
      for (int l = 0; l < 4; l++)
        if (!ln[l]) cur[8*l +: 8] = x.data[8*l +: 8];
      ref_mem[key] = cur;
    end else if (k == 0) begin
      e.rdy = 1'b0;
      e.csn[4*bank +: 4] = ln;
      e.chk_addr = 1;
    end else if (k < dlen(d, x) - 1) begin
      e.rdy = 1'b0;
    end else begin
      e.rdata = ref_mem.exists(key) ? ref_mem[key] : 32'hx;
      e.fin_rd = 1;
    end
    return e;
  endfunction

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic pop(input int d, output exp_t e);
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
  endtask

  // Present one address phase; it is held through the previous data phase.
  task automatic issue(input int d, input logic sel, input logic rdy,
                       input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] a,
                       input logic [31:0] data);
    xfer_t x;
    int n;
    x = mk(sel, rdy, trans, wr, size, a, data);
    n = dlen(d, prev[d]);
    hsel_s[d] = sel; hready_s[d] = rdy; htrans_s[d] = trans;
    hwrite_s[d] = wr; hsize_s[d] = size; haddr_s[d] = a;
    hburst_s[d] = 3'b001;
    hwdata_s[d] = prev[d].data;
    for (int k = 0; k < n; k++) begin
      push(d, rec(d, prev[d], k));
      @(posedge hclk); #1;
    end
    prev[d] = x;
  endtask

  task automatic wr(input int d, input logic [2:0] size,
                    input logic [31:0] a, input logic [31:0] data);
    issue(d, 1'b1, 1'b1, 2'b10, 1'b1, size, a, data);
  endtask

  task automatic rd(input int d, input logic [2:0] size, input logic [31:0] a);
    issue(d, 1'b1, 1'b1, 2'b10, 1'b0, size, a, 32'h0);
  endtask

  task automatic idle(input int d);
    issue(d, 1'b0, 1'b1, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic chk_reset_vals(input int d, input string tag);
    chk(d, {tag, " hready_resp"}, 64'(rdy_o[d]), 64'h1);
    chk(d, {tag, " hresp"}, 64'(resp_o[d]), 64'h0);
    chk(d, {tag, " hrdata"}, 64'(rdata_o[d]), 64'h0);
    chk(d, {tag, " sram_w_en"}, 64'(wen_o[d]), 64'h1);
    chk(d, {tag, " bank_csn"}, 64'(csn_o[d]), 64'hFF);
    chk(d, {tag, " sram_addr_out"}, 64'(addr_o[d]), 64'h0);
  endtask

  // Compare process: every cycle with a queued expectation is checked.
  always begin
    exp_t e;
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      if (rst_s[d] == 1'b0) begin
        if (rdy_o[d] == 1'b0) low_run[d]++;
        else if (low_run[d] != 0) begin
          last_low[d] = low_run[d];
          low_run[d] = 0;
        end
        if (resp_o[d] == 2'b01) err_cyc[d]++;
      end
      if (qsize(d) > 0) begin
        pop(d, e);
        chk(d, "hready_resp", 64'(rdy_o[d]), 64'(e.rdy));
        chk(d, "hresp", 64'(resp_o[d]), 64'(e.resp));
        chk(d, "hrdata", 64'(rdata_o[d]), 64'(e.rdata));
        chk(d, "sram_w_en", 64'(wen_o[d]), 64'(e.wen));
        chk(d, "bank_csn", 64'(csn_o[d]), 64'(e.csn));
        if (e.chk_addr)
          chk(d, "sram_addr_out", 64'(addr_o[d]), 64'(e.addr));
        if (e.chk_wdata)
          chk(d, "sram_wdata", 64'(wdata_o[d]), 64'(e.wdata));
        if (e.fin_rd) last_rd[d] = rdata_o[d];
        if (e.is_wr) begin
          last_wcsn[d] = csn_o[d];
          last_waddr[d] = addr_o[d];
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1;
      hsel_s[d] = 1'b0; hwrite_s[d] = 1'b0; hready_s[d] = 1'b1;
      hsize_s[d] = 3'd0; htrans_s[d] = 2'b00; hburst_s[d] = 3'd0;
      haddr_s[d] = 32'h0; hwdata_s[d] = 32'h0;
      prev[d] = mk(1'b0, 1'b1, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
      low_run[d] = 0; last_low[d] = 0; err_cyc[d] = 0;
      last_rd[d] = 32'h0; last_wcsn[d] = 8'h0; last_waddr[d] = 13'h0;
    end
    repeat (2) @(posedge hclk);
    #1;
    chk_reset_vals(0, "reset");
    chk_reset_vals(1, "reset");
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;

    // Word write/read in bank 1
    wr(0, 3'd2, 32'h0000_8004, 32'hDEAD_BEEF);
    rd(0, 3'd2, 32'h0000_8004);
    idle(0);
    chk(0, "wr csn 0x8004", 64'(last_wcsn[0]), 64'h0F);
    chk(0, "wr addr 0x8004", 64'(last_waddr[0]), 64'h1);
    chk(0, "rd 0x8004", 64'(last_rd[0]), 64'hDEAD_BEEF);
    chk(0, "rd wait cycles", 64'(last_low[0]), 64'd1);

    // Back-to-back byte writes then word read
    wr(0, 3'd0, 32'h0000_0010, 32'h0000_0011);
    wr(0, 3'd0, 32'h0000_0011, 32'h0000_2200);
    wr(0, 3'd0, 32'h0000_0012, 32'h0033_0000);
    wr(0, 3'd0, 32'h0000_0013, 32'h4400_0000);
    rd(0, 3'd2, 32'h0000_0010);
    idle(0);
    chk(0, "byte3 csn", 64'(last_wcsn[0]), 64'hF7);
    chk(0, "rd 0x10", 64'(last_rd[0]), 64'h4433_2211);

    // Misaligned halfword -> ERROR, then legal write and read
    wr(0, 3'd1, 32'h0000_0001, 32'h0000_BEEF);
    wr(0, 3'd2, 32'h0000_0020, 32'hCAFE_F00D);
    rd(0, 3'd2, 32'h0000_0020);
    idle(0);
    chk(0, "err cycles halfword", 64'(err_cyc[0]), 64'd2);
    chk(0, "rd 0x20", 64'(last_rd[0]), 64'hCAFE_F00D);

    // Out of range, oversize, misaligned word, then a legal halfword read
    rd(0, 3'd2, 32'h0001_0000);
    wr(0, 3'd3, 32'h0000_0020, 32'h1234_5678);
    rd(0, 3'd2, 32'h0000_0022);
    rd(0, 3'd1, 32'h0000_0022);
    idle(0);
    chk(0, "err cycles total", 64'(err_cyc[0]), 64'd8);
    chk(0, "rd half 0x22", 64'(last_rd[0]), 64'hCAFE_F00D);

    // Phases that must not be accepted: hready low, BUSY
    issue(0, 1'b1, 1'b0, 2'b10, 1'b1, 3'd2, 32'h0000_8004, 32'h0);
    issue(0, 1'b1, 1'b1, 2'b01, 1'b1, 3'd2, 32'h0000_8004, 32'h0);
    rd(0, 3'd2, 32'h0000_8004);
    idle(0);
    chk(0, "rd 0x8004 again", 64'(last_rd[0]), 64'hDEAD_BEEF);

    // RD_WAIT=3 instance
    wr(1, 3'd2, 32'h0000_0004, 32'h0BAD_F00D);
    rd(1, 3'd2, 32'h0000_0004);
    idle(1);
    chk(1, "rd wait cycles", 64'(last_low[1]), 64'd4);
    chk(1, "rd 0x4", 64'(last_rd[1]), 64'h0BAD_F00D);
    wr(1, 3'd2, 32'h0000_FFFC, 32'h1234_5678);
    rd(1, 3'd2, 32'h0000_FFFC);
    idle(1);
    chk(1, "wr addr top", 64'(last_waddr[1]), 64'h1FFF);
    chk(1, "rd top word", 64'(last_rd[1]), 64'h1234_5678);

    // Reset pulse inside the read wait count
    wr(1, 3'd2, 32'h0000_0008, 32'h55AA_55AA);
    rd(1, 3'd2, 32'h0000_0008);
    hsel_s[1] = 1'b0; htrans_s[1] = 2'b00; hwdata_s[1] = 32'h0;
    push(1, rec(1, prev[1], 0));
    @(posedge hclk); #1;
    push(1, rec(1, prev[1], 1));
    @(posedge hclk); #1;
    rst_s[1] = 1'b1;
    #1;
    chk_reset_vals(1, "mid-read reset");
    low_run[1] = 0;
    @(posedge hclk); #1;
    rst_s[1] = 1'b0;
    prev[1] = mk(1'b0, 1'b1, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0);
    wr(1, 3'd2, 32'h0000_0008, 32'h600D_CAFE);
    rd(1, 3'd2, 32'h0000_0008);
    idle(1);
    chk(1, "rd after reset", 64'(last_rd[1]), 64'h600D_CAFE);

    repeat (2) @(posedge hclk);
    #1;
    chk(0, "queue drained", 64'(qsize(0)), 64'd0);
    chk(1, "queue drained", 64'(qsize(1)), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_sram_if_mb.md
Name: ahb_sram_if_mb

Overview:
- Parametrised next-generation AHB-Lite slave interface for the SRAM controller. Decodes AHB transfers into per-bank, per-byte-lane chip selects for an array of NUM_BANKS banks; each bank is four 8-bit synchronous SRAMs.
- New relative to the single-cycle two-bank interface:
  - configurable bank count and depth;
  - read wait states matched to synchronous SRAM latency;
  - two-cycle ERROR response for illegal transfers.
- Sits between the AHB fabric and the sram_core bank array.

Parameters:
- NUM_BANKS, 2, number of 32-bit banks; power of 2, 1..8.
- BANK_AW, 13, word-address width per bank (bank = 2^BANK_AW x 32).
- RD_WAIT, 0, extra read wait states beyond the mandatory one, 0..3.
- Derived: BSEL_W = log2(NUM_BANKS), min 1. Byte range = NUM_BANKS * 2^(BANK_AW+2).

Ports:
- hclk  in  1  clock
- hreset  in  1  asynchronous active-high reset
- hsel, hwrite, hready  in  1 each  AHB select, direction, bus ready
- hsize  in  3  AHB size
- htrans  in  2  AHB transfer type
- hburst  in  3  AHB burst (ignored)
- haddr  in  32  AHB address
- hwdata  in  32  AHB write data
- sram_rdata  in  NUM_BANKS*32  bank read data; bank b at [32b+31:32b]
- hready_resp  out  1  slave ready
- hresp  out  2  00 OKAY, 01 ERROR
- hrdata  out  32  read data
- sram_w_en  out  1  0 = write, 1 = read/idle
- sram_addr_out  out  BANK_AW  word address in bank
- sram_wdata  out  32  write data (= hwdata)
- bank_csn  out  NUM_BANKS*4  active-low byte-lane selects; bank b at [4b+3:4b]

Behaviour:
- Reset values (asynchronous): FSM = IDLE, hready_resp = 1, hresp = 00, hrdata = 0, sram_w_en = 1, bank_csn = all 1, sram_addr_out = 0, wait counter = 0.
- Address phase accepted when hsel & hready & htrans[1] (NONSEQ/SEQ). Accepted phase registers addr, size, write, bank index and the error flag. IDLE/BUSY or unselected: zero-wait OKAY, no SRAM access.
- Illegal transfer, any of:
  - hsize > 2;
  - halfword with haddr[0] = 1;
  - word with haddr[1:0] != 0;
  - haddr >= byte range.
- FSM states: IDLE, WR, RD, RD_WAIT, ERR1, ERR2.
- Transitions from IDLE/WR/final RD cycle/ERR2 on each accepted phase:
  - error -> ERR1;
  - write -> WR;
  - read -> RD;
  - nothing accepted -> IDLE.
- WR (1 cycle):
  - hready_resp = 1; sram_w_en = 0.
  - Selected bank gets lane csn; sram_addr_out = registered addr[BANK_AW+1:2]; sram_wdata = hwdata.
  - Back-to-back writes are zero-wait.
- RD, cycle D0:
  - csn asserted, sram_w_en = 1, hready_resp = 0.
  - Then RD_WAIT cycles in RD_WAIT with hready_resp = 0 and csn deasserted; 2-bit counter.
  - Final cycle: hready_resp = 1, hrdata = selected bank's sram_rdata; the next phase may be accepted.
  - Read data phase = 2 + RD_WAIT cycles.
  - hrdata = 0 whenever not in the final read cycle.
- ERR1: hresp = 01, hready_resp = 0. ERR2: hresp = 01, hready_resp = 1. No csn is asserted in either state.
- Lane csn (0 = selected):
  - word: 0000;
  - halfword: addr[1] = 0 -> 1100, addr[1] = 1 -> 0011;
  - byte: addr[1:0] 00/01/10/11 -> 1110/1101/1011/0111.
  - Reads use the same lane pattern.
- Bank index = registered addr[BANK_AW+1+BSEL_W : BANK_AW+2]; for NUM_BANKS = 1 it is 0.
- While hready_resp = 0, hsel/hready from the master are not sampled as a new phase.
- Write immediately followed by read of the same address returns the new data (the write is committed at the end of the WR cycle).
- Reset asserted mid-read or mid-error: immediate return to reset values; the pending transfer is dropped.

Test Plan:
- Word write 0xDEADBEEF to 0x0000_8004, then word read -> bank_csn[7:4] = 0000 during WR, sram_addr_out = 1; read returns 0xDEADBEEF with hready_resp low 1 cycle (RD_WAIT = 0).
- Byte writes 0x11, 0x22, 0x33, 0x44 to 0x0000_0010..13 back-to-back -> csn patterns 1110/1101/1011/0111, zero wait; word read of 0x10 returns 0x44332211.
- Halfword write to 0x0000_0001 -> ERR1 (hresp 01, hready_resp 0) then ERR2 (hresp 01, hready_resp 1); no csn is asserted; the next legal transfer gets OKAY.
- Read of 0x0001_0000 (beyond the 64 KB range) -> two-cycle ERROR; hsize = 3'b011 -> ERROR.
- RD_WAIT = 3 rebuild: read of a word written as 0x0BADF00D -> hready_resp low 4 cycles, then data; master holds next phase until accepted.
- hreset pulsed during the RD_WAIT counter -> outputs go to reset values the same cycle; a following write completes normally.
